// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: configurable frame width, runtime divider, CPOL/CPHA,
// bit order and decoded active-low slave selects. Start/ready front-end handshake.
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_SS = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EC_W = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              cpha_q, lsb_q;
    logic [DIV_W-1:0]  div_q, hcnt;
    logic [EC_W-1:0]   ecnt;
    logic [NUM_SS-1:0] ss_dec;
    logic              accept, hp_end, last_edge, sample, shift;

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        sample    = 1'b0;
        shift     = 1'b0;
        hp_end    = (hcnt == div_q);
        last_edge = (ecnt == EC_W'(2 * DATA_W - 2));
        for (int i = 0; i < NUM_SS; i++)
            ss_dec[i] = (cs_sel != SEL_W'(i));
        case (state)
            IDLE: if (start && ready) begin
                accept  = 1'b1;
                state_d = SETUP;
            end
            // Edge 1 closes SETUP: it samples for cpha=0 and never shifts.
            SETUP: if (hp_end) begin
                sample  = !cpha_q;
                state_d = XFER;
            end
            // In XFER the edge number is ecnt+2, so its parity is ecnt[0].
            XFER: if (hp_end) begin
                sample = ecnt[0] ^ cpha_q;
                shift  = !(ecnt[0] ^ cpha_q);
                if (last_edge) state_d = HOLD;
            end
            HOLD: if (hp_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            hcnt     <= '0;
            ecnt     <= '0;
        end else begin
            state    <= state_d;
            ready    <= (state_d == IDLE);
            busy     <= (state_d != IDLE);
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                sclk <= cpol;
                hcnt <= '0;
                ecnt <= '0;
                if (accept) begin
                    tx_sh  <= tx_data;
                    rx_sh  <= '0;
                    cpha_q <= cpha;
                    lsb_q  <= lsb_first;
                    div_q  <= clk_div;
                    mosi   <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    ss_n   <= ss_dec;
                end else begin
                    mosi <= 1'b0;
                    ss_n <= '1;
                end
            end else begin
                hcnt <= hp_end ? '0 : hcnt + 1'b1;
                if (hp_end && state != HOLD)
                    sclk <= ~sclk;
                if (hp_end && state == XFER)
                    ecnt <= ecnt + 1'b1;
                if (sample)
                    rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
                if (shift) begin
                    tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
                    mosi  <= lsb_q ? tx_sh[1] : tx_sh[DATA_W-2];
                end
                if (hp_end && state == HOLD) begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                    ss_n     <= '1;
                    mosi     <= 1'b0;
                    sclk     <= cpol;
                end
            end
        end
    end

endmodule
